// File: rtl/ram_scan_if.sv
// Frame RAM read port and LED panel serial/latch signals driven by ram_scan_driver.
interface ram_scan_if;
    logic       ram_clk;
    logic [7:0] ram_addr;
    logic [7:0] ram_dout;
    logic       ser_dat;
    logic       ser_clk;
    logic       ser_lat;
    logic       blank;
    logic [4:0] row;
    logic       frame_done;
    logic       idle;

    modport master (
        input  ram_dout,
        output ram_clk, ram_addr, ser_dat, ser_clk, ser_lat, blank, row, frame_done, idle
    );

    modport slave (
        output ram_dout,
        input  ram_clk, ram_addr, ser_dat, ser_clk, ser_lat, blank, row, frame_done, idle
    );
endinterface

// File: rtl/ram_scan_driver.sv
// Scans a column/line frame RAM and shifts each line MSB-first into an LED panel,
// latching and lighting it for DWELL cycles while the next line is fetched.
module ram_scan_driver #(
    parameter logic [7:0] DWELL    = 8'd64,
    parameter logic [2:0] MAX_COL  = 3'd7,
    parameter logic [4:0] MAX_LINE = 5'd31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    ram_scan_if.master bus
);

    localparam int unsigned COL_W   = 3;
    localparam int unsigned LINE_W  = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BIT_W   = 3;
    localparam int unsigned DWELL_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_HI, S_RD_LO, S_SH_LO, S_SH_HI, S_BLANK, S_LATCH, S_DWELL
    } state_t;

    state_t                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [DATA_W-1:0]       shreg_q, shreg_d;
    logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic [COL_W+LINE_W-1:0] ram_addr_q, ram_addr_d;
    logic                    ram_clk_q, ram_clk_d;
    logic                    ser_dat_q, ser_dat_d;
    logic                    ser_clk_q, ser_clk_d;
    logic                    ser_lat_q, ser_lat_d;
    logic                    blank_q, blank_d;
    logic [LINE_W-1:0]       row_q, row_d;
    logic                    frame_done_q, frame_done_d;
    logic                    idle_q, idle_d;

    // Next state, counters, and Moore outputs decoded from the next state so they align with it
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        line_d       = line_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        dwell_d      = dwell_q;
        ram_addr_d   = ram_addr_q;
        ser_dat_d    = ser_dat_q;
        row_d        = row_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!pause) begin
                    col_d   = '0;
                    line_d  = '0;
                    state_d = S_RD_HI;
                end
            end
            S_RD_HI: state_d = S_RD_LO;
            S_RD_LO: begin
                shreg_d  = bus.ram_dout;
                bitcnt_d = BIT_W'(7);
                state_d  = S_SH_LO;
                // Present the next read address now, while ram_clk stays low for many cycles
                if (col_q != MAX_COL) begin
                    ram_addr_d = {COL_W'(col_q + COL_W'(1)), line_q};
                end else if (line_q != MAX_LINE) begin
                    ram_addr_d = {COL_W'(0), LINE_W'(line_q + LINE_W'(1))};
                end else begin
                    ram_addr_d = '0;
                end
            end
            S_SH_LO: state_d = S_SH_HI;
            S_SH_HI: begin
                shreg_d = shreg_q << 1;
                if (bitcnt_q != '0) begin
                    bitcnt_d = BIT_W'(bitcnt_q - BIT_W'(1));
                    state_d  = S_SH_LO;
                end else if (col_q != MAX_COL) begin
                    col_d   = COL_W'(col_q + COL_W'(1));
                    state_d = S_RD_HI;
                end else begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: state_d = S_LATCH;
            S_LATCH: begin
                dwell_d = DWELL;
                state_d = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_q > DWELL_W'(1)) begin
                    dwell_d = DWELL_W'(dwell_q - DWELL_W'(1));
                end else begin
                    dwell_d = '0;
                    col_d   = '0;
                    if (line_q != MAX_LINE) begin
                        line_d  = LINE_W'(line_q + LINE_W'(1));
                        state_d = S_RD_HI;
                    end else begin
                        line_d       = '0;
                        frame_done_d = 1'b1;
                        state_d      = pause ? S_IDLE : S_RD_HI;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_SH_LO) ser_dat_d = shreg_d[DATA_W-1];
        if (state_d == S_LATCH) row_d = line_q;

        ram_clk_d = (state_d == S_RD_HI);
        ser_clk_d = (state_d == S_SH_HI);
        ser_lat_d = (state_d == S_LATCH);
        blank_d   = (state_d != S_DWELL);
        idle_d    = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            line_q       <= '0;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            dwell_q      <= '0;
            ram_addr_q   <= '0;
            ram_clk_q    <= 1'b0;
            ser_dat_q    <= 1'b0;
            ser_clk_q    <= 1'b0;
            ser_lat_q    <= 1'b0;
            blank_q      <= 1'b1;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_q       <= line_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            dwell_q      <= dwell_d;
            ram_addr_q   <= ram_addr_d;
            ram_clk_q    <= ram_clk_d;
            ser_dat_q    <= ser_dat_d;
            ser_clk_q    <= ser_clk_d;
            ser_lat_q    <= ser_lat_d;
            blank_q      <= blank_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            idle_q       <= idle_d;
        end
    end

    assign bus.ram_clk    = ram_clk_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ser_dat    = ser_dat_q;
    assign bus.ser_clk    = ser_clk_q;
    assign bus.ser_lat    = ser_lat_q;
    assign bus.blank      = blank_q;
    assign bus.row        = row_q;
    assign bus.frame_done = frame_done_q;
    assign bus.idle       = idle_q;

endmodule

// File: tb/tb_ram_scan_driver.sv
// Directed bench for ram_scan_driver with a frame RAM model and a panel-side protocol monitor.
module tb_ram_scan_driver;

    localparam logic [7:0] DW       = 8'd4;
    localparam int         LINE_CYC = 150;

    logic clk = 1'b0;
    logic rst;
    logic pause;
    int   mode = 0;
    int   cyc  = 0;

    int   checks = 0;
    int   passed = 0;

    logic bits_q[$];
    int   lat_cyc[$];
    int   lat_row[$];
    int   fd_n     = 0;
    int   fd_cyc   = 0;
    int   prot_err = 0;

    logic       prev_sclk = 1'b0;
    logic       prev_sdat = 1'b0;
    logic       prev_lat  = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    ram_scan_if bus ();

    ram_scan_driver #(
        .DWELL   (DW),
        .MAX_COL (3'd7),
        .MAX_LINE(5'd31)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pause(pause),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame RAM: byte(col,line) = {col,line}, or constant fill
    assign bus.ram_dout = (mode == 0) ? bus.ram_addr : ((mode == 1) ? 8'hFF : 8'h00);

    always @(negedge clk) begin
        if (bus.ser_clk && !prev_sclk) bits_q.push_back(bus.ser_dat);
        if (bus.ser_lat) begin
            lat_cyc.push_back(cyc);
            lat_row.push_back(int'(bus.row));
        end
        if (bus.frame_done) begin
            fd_n   = fd_n + 1;
            fd_cyc = cyc;
        end
        if (bus.ser_lat && !bus.blank) prot_err++;
        if (bus.ser_lat && prev_lat) prot_err++;
        if (bus.ram_clk && (bus.ram_addr !== prev_addr)) prot_err++;
        if ((bus.ser_lat || !bus.blank) && bus.ser_clk) prot_err++;
        if (bus.ser_clk && (bus.ser_dat !== prev_sdat)) prot_err++;
        prev_sclk = bus.ser_clk;
        prev_sdat = bus.ser_dat;
        prev_lat  = bus.ser_lat;
        prev_addr = bus.ram_addr;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int         t0;
        int         ok;
        int         ones;
        int         bad;
        logic [7:0] b;

        rst   = 1'b1;
        pause = 1'b0;
        mode  = 0;
        repeat (3) tick();

        chk("rst_ram_clk",    32'(bus.ram_clk), 32'd0);
        chk("rst_ram_addr",   32'(bus.ram_addr), 32'd0);
        chk("rst_ser_clk",    32'(bus.ser_clk), 32'd0);
        chk("rst_ser_dat",    32'(bus.ser_dat), 32'd0);
        chk("rst_ser_lat",    32'(bus.ser_lat), 32'd0);
        chk("rst_blank",      32'(bus.blank), 32'd1);
        chk("rst_row",        32'(bus.row), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_idle",       32'(bus.idle), 32'd1);

        // Frame 1: line 0 stream, latch timing, whole-frame sequencing
        rst = 1'b0;
        ok  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ram_clk) begin ok = 1; break; end
        end
        chk("first_read_seen", 32'(ok), 32'd1);
        t0 = cyc;
        chk("first_read_addr", 32'(bus.ram_addr), 32'd0);
        chk("idle_low_running", 32'(bus.idle), 32'd0);

        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.ser_lat) begin ok = 1; break; end
        end
        chk("lat0_seen", 32'(ok), 32'd1);
        chk("lat0_cycle", 32'(cyc - t0), 32'd145);
        chk("lat0_row", 32'(bus.row), 32'd0);
        chk("lat0_blank", 32'(bus.blank), 32'd1);
        chk("line0_bitcount", 32'(bits_q.size()), 32'd64);
        for (int c = 0; c < 8; c++) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], bits_q[c*8 + k]};
            chk($sformatf("line0_byte%0d", c), 32'(b), 32'(c << 5));
        end
        tick();
        chk("dwell_blank_low", 32'(bus.blank), 32'd0);

        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (bus.frame_done) begin ok = 1; break; end
        end
        chk("frame1_done_seen", 32'(ok), 32'd1);
        chk("frame1_length", 32'(fd_cyc - t0), 32'(32 * LINE_CYC));
        chk("frame1_fd_count", 32'(fd_n), 32'd1);
        chk("frame1_lat_count", 32'(lat_cyc.size()), 32'd32);
        chk("frame1_bitcount", 32'(bits_q.size()), 32'd2048);
        if (lat_cyc.size() == 32) begin
            for (int i = 0; i < 32; i++) chk($sformatf("frame1_row%0d", i), 32'(lat_row[i]), 32'(i));
            chk("frame1_lat31_cycle", 32'(lat_cyc[31] - t0), 32'(31 * LINE_CYC + 145));
        end
        if (bits_q.size() == 2048) begin
            for (int c = 0; c < 8; c += 7) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++) b = {b[6:0], bits_q[(31*8 + c)*8 + k]};
                chk($sformatf("line31_byte%0d", c), 32'(b), 32'((c << 5) | 31));
            end
        end
        tick();
        chk("frame_done_one_cycle", 32'(bus.frame_done), 32'd0);
        chk("no_idle_when_running", 32'(bus.idle), 32'd0);
        lat_cyc.delete();
        lat_row.delete();
        bits_q.delete();
        fd_n = 0;

        // Frame 2: pause raised mid-frame takes effect only at the frame boundary
        ok = 0;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (bus.row == 5'd10) begin ok = 1; break; end
        end
        chk("row10_seen", 32'(ok), 32'd1);
        pause = 1'b1;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (bus.frame_done) begin ok = 1; break; end
        end
        chk("frame2_done_seen", 32'(ok), 32'd1);
        chk("frame2_lat_count", 32'(lat_row.size()), 32'd32);
        if (lat_row.size() > 0) chk("frame2_last_row", 32'(lat_row[lat_row.size()-1]), 32'd31);
        chk("paused_idle", 32'(bus.idle), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.idle || !bus.blank || bus.ram_clk || bus.ser_clk || bus.ser_lat) bad++;
        end
        chk("paused_static", 32'(bad), 32'd0);

        pause = 1'b0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ram_clk) begin ok = 1; break; end
        end
        chk("resume_read_seen", 32'(ok), 32'd1);
        chk("resume_addr", 32'(bus.ram_addr), 32'd0);

        // Reset during SH_HI of line 5 (line 4 on display)
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (bus.row == 5'd4) begin ok = 1; break; end
        end
        chk("row4_seen", 32'(ok), 32'd1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ser_clk) begin ok = 1; break; end
        end
        chk("line5_shift_seen", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ser_clk",    32'(bus.ser_clk), 32'd0);
        chk("mid_rst_ser_dat",    32'(bus.ser_dat), 32'd0);
        chk("mid_rst_ser_lat",    32'(bus.ser_lat), 32'd0);
        chk("mid_rst_ram_clk",    32'(bus.ram_clk), 32'd0);
        chk("mid_rst_blank",      32'(bus.blank), 32'd1);
        chk("mid_rst_row",        32'(bus.row), 32'd0);
        chk("mid_rst_idle",       32'(bus.idle), 32'd1);
        chk("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);

        mode = 1;
        tick();
        tick();
        bits_q.delete();
        lat_row.delete();
        rst = 1'b0;
        ok  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ram_clk) begin ok = 1; break; end
        end
        chk("post_rst_read_seen", 32'(ok), 32'd1);
        chk("post_rst_addr", 32'(bus.ram_addr), 32'd0);

        // Constant fills: all-ones line then all-zeros line
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.ser_lat) begin ok = 1; break; end
        end
        chk("ff_lat_seen", 32'(ok), 32'd1);
        chk("ff_row", 32'(bus.row), 32'd0);
        ones = 0;
        foreach (bits_q[i]) if (bits_q[i] === 1'b1) ones++;
        chk("ff_bitcount", 32'(bits_q.size()), 32'd64);
        chk("ff_ones", 32'(ones), 32'd64);

        mode = 2;
        bits_q.delete();
        tick();
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.ser_lat) begin ok = 1; break; end
        end
        chk("zero_lat_seen", 32'(ok), 32'd1);
        chk("zero_row", 32'(bus.row), 32'd1);
        ones = 0;
        foreach (bits_q[i]) if (bits_q[i] !== 1'b0) ones++;
        chk("zero_bitcount", 32'(bits_q.size()), 32'd64);
        chk("zero_nonzero_bits", 32'(ones), 32'd0);

        chk("protocol_violations", 32'(prot_err), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram_scan_driver.md
RAM_SCAN_DRIVER -- requirements
Module: ram_scan_driver

Interface
REQ-001 Parameter DWELL, default 8'd64: display dwell per line, in clk cycles; legal range 1..255.
REQ-002 Parameter MAX_COL, default 3'd7: last column index.
REQ-003 Parameter MAX_LINE, default 5'd31: last line index.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 pause  in  1  request to release the frame RAM; sampled only at frame boundary.
REQ-007 ram_dout  in  8  frame RAM read data.
REQ-008 ram_clk  out  1  frame RAM clock, driven by this block.
REQ-009 ram_addr  out  8  frame RAM address = {col[2:0], line[4:0]}; col is the column index, line is the line index; no inversion.
REQ-010 ser_dat  out  1  serial pixel data to the panel shift chain.
REQ-011 ser_clk  out  1  panel shift clock; data is taken on its rising edge.
REQ-012 ser_lat  out  1  panel latch strobe, one clk cycle high.
REQ-013 blank  out  1  panel output disable; 1 means dark.
REQ-014 row  out  5  currently displayed line select.
REQ-015 frame_done  out  1  one-cycle pulse after line MAX_LINE completes.
REQ-016 idle  out  1  high while parked in IDLE; while high, the RAM may be driven by another block.

Function
REQ-017 State set: IDLE, RD_HI, RD_LO, SH_LO, SH_HI, BLANK, LATCH, DWELL.
REQ-018 IDLE: if pause=0, go to RD_HI with col=0, line=0; otherwise stay; idle=1 only in this state.
REQ-019 RD_HI: ram_clk=1, then go to RD_LO.
REQ-020 RD_LO: ram_clk=0, load ram_dout into an 8-bit shift register, set bit counter to 7, then go to SH_LO.
REQ-021 SH_LO: ser_clk=0, ser_dat=shreg[7], then go to SH_HI.
REQ-022 SH_HI: ser_clk=1, shift shreg left by 1; if bitcnt>0, decrement it and return to SH_LO.
REQ-023 SH_HI with bitcnt=0 and col<MAX_COL: increment col, then go to RD_HI.
REQ-024 SH_HI with bitcnt=0 and col=MAX_COL: go to BLANK.
REQ-025 Bit order: column 0 first, MSB first within each byte; 64 ser_clk rising edges per line.
REQ-026 Per-line serial cost: 8 × (2 read cycles + 16 shift cycles) = 144 cycles.
REQ-027 BLANK: blank=1, ser_clk=0, then go to LATCH.
REQ-028 LATCH: ser_lat=1 for one cycle, row<=line, load dwell counter with DWELL, then go to DWELL.
REQ-029 DWELL: blank=0; decrement the counter each cycle; when counter=1, set blank=1.
REQ-030 DWELL exit, line<MAX_LINE: line+1, col=0, go to RD_HI.
REQ-031 DWELL exit, line=MAX_LINE: frame_done=1 for one cycle, line=0, col=0; go to IDLE if pause=1, else go to RD_HI.
REQ-032 pause asserted mid-frame has no effect until the frame boundary; the current frame completes.
REQ-033 The panel shows line N while line N+1 is being shifted; blank stays 1 from BLANK through the end of LATCH.
REQ-034 ram_addr changes only while ram_clk=0.
REQ-035 ser_dat is stable during the whole SH_LO→SH_HI pair.
REQ-036 All counters wrap only as specified above; no implicit overflow.

Reset
REQ-037 While rst=1: state=IDLE, col=0, line=0, shreg=0, ram_clk=0, ser_clk=0, ser_dat=0, ser_lat=0, blank=1, row=0, frame_done=0, idle=1.
REQ-038 rst asserted mid-line aborts immediately with no partial latch.
REQ-039 After rst falls, scanning restarts at line 0, column 0.

Verification
REQ-040 RAM model byte(col,line) = {col,line}; pause=0; release reset → line 0 serial stream is 0x00,0x20,0x40,…,0xE0 MSB-first; ser_lat pulses at cycle 145; row=0.
REQ-041 DWELL=4, run one frame → exactly 32 ser_lat pulses, row sequence 0..31, one frame_done pulse, 32×(144+2+4) cycles per frame.
REQ-042 pause=1 asserted during line 10 → frame completes through line 31, then idle=1, blank=1, ram_clk static; pause=0 → restart at line 0.
REQ-043 rst pulse during SH_HI of line 5 → all outputs at reset values that cycle; after release, first read is ram_addr=0x00.
REQ-044 Protocol checker, whole frame → blank=1 whenever ser_lat=1; ram_addr stable while ram_clk=1; no ser_clk edge in BLANK/LATCH/DWELL.
REQ-045 All bytes 0xFF then all bytes 0x00 → ser_dat constant 1 (respectively 0) across all 64 clocks of every line.
